uart_dbg_soc_top: RTL and testbench

// FPGA top for the ProFPGA XC7V2000T board. A UART 8N1 host link drives a packet bridge into a
// 32-bit memory-mapped space: 256-word scratch register file, soft-reset register, ID register.

---
 rtl/uart_dbg_soc_top_if.sv | 10 +
 rtl/uart_dbg_soc_top.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_dbg_soc_top.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_dbg_soc_top_if.sv
// UART host link for uart_dbg_soc_top: 8N1 data lines plus active-low CTS/RTS flow control.
interface uart_dbg_soc_top_if;
  logic uart_rxd;
  logic uart_txd;
  logic uart_cts;
  logic uart_rts;

  modport master (output uart_rxd, output uart_cts, input uart_txd, input uart_rts);
  modport slave  (input uart_rxd, input uart_cts, output uart_txd, output uart_rts);
endinterface

// File: rtl/uart_dbg_soc_top.sv
// ProFPGA debug top: UART 8N1 packet bridge into a 32-bit space (scratch regs, soft reset, ID).
// Optional feature: define UART_RX_TIMEOUT_EN to abort packets stalled longer than RX_TIMEOUT cycles.
module uart_dbg_soc_top #(
  parameter int unsigned SIMULATION   = 1,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h6000_0000,
  parameter int unsigned NUM_REGS     = 256,
  parameter int unsigned RX_TIMEOUT   = 4096
) (
  input  logic              clk_board_p,
  input  logic              clk_board_n,
  input  logic              reset,
  input  logic              profpga_sync0_p,
  input  logic              profpga_sync0_n,
  uart_dbg_soc_top_if.slave uart,
  output logic              LED_RED,
  output logic              LED_GREEN,
  output logic              LED_BLUE,
  output logic              LED_YELLOW
);

  localparam int HB_W  = (SIMULATION != 0) ? 7 : 27;
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      REG_SPAN  = 32'(4 * NUM_REGS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] DEC_REG  = 2'd0;
  localparam logic [1:0] DEC_SOFT = 2'd1;
  localparam logic [1:0] DEC_ID   = 2'd2;
  localparam logic [1:0] DEC_BAD  = 2'd3;

  function automatic logic [1:0] decode(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if (off[1:0] != 2'b00)       decode = DEC_BAD;
    else if (off < REG_SPAN)     decode = DEC_REG;
    else if (off == 32'h400)     decode = DEC_SOFT;
    else if (off == 32'h404)     decode = DEC_ID;
    else                         decode = DEC_BAD;
  endfunction

  function automatic logic [IDX_W-1:0] regIdx(input logic [31:0] addr);
    regIdx = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic w_unusedPins;
  assign w_unusedPins = clk_board_n ^ profpga_sync0_p ^ profpga_sync0_n;

  logic [HB_W-1:0] r_hb;
  always_ff @(posedge clk_board_p) begin
    if (reset) r_hb <= '0;
    else       r_hb <= r_hb + 1'b1;
  end

  logic r_rxdMeta, r_rxdSync;
  always_ff @(posedge clk_board_p) begin
    if (reset) begin
      r_rxdMeta <= 1'b1;
      r_rxdSync <= 1'b1;
    end else begin
      r_rxdMeta <= uart.uart_rxd;
      r_rxdSync <= r_rxdMeta;
    end
  end

  // Receiver: bit index 0 is the start bit (half-bit wait), 1..8 data, 9 stop.
  logic             r_rxBusy;
  logic [CNT_W-1:0] r_rxCnt;
  logic [3:0]       r_rxBit;
  logic [7:0]       r_rxShift;
  logic             r_rxValid;
  logic [7:0]       r_rxData;
  always_ff @(posedge clk_board_p) begin
    if (reset) begin
      r_rxBusy  <= 1'b0;
      r_rxCnt   <= '0;
      r_rxBit   <= '0;
      r_rxShift <= '0;
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
    end else begin
      r_rxValid <= 1'b0;
      if (!r_rxBusy) begin
        if (!r_rxdSync) begin
          r_rxBusy <= 1'b1;
          r_rxCnt  <= '0;
          r_rxBit  <= '0;
        end
      end else if (r_rxCnt == ((r_rxBit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        r_rxCnt <= '0;
        r_rxBit <= r_rxBit + 4'd1;
        if (r_rxBit == 4'd0) begin
          if (r_rxdSync) r_rxBusy <= 1'b0;
        end else if (r_rxBit == 4'd9) begin
          r_rxBusy <= 1'b0;
          if (r_rxdSync) begin
            r_rxValid <= 1'b1;
            r_rxData  <= r_rxShift;
          end
        end else begin
          r_rxShift <= {r_rxdSync, r_rxShift[7:1]};
        end
      end else begin
        r_rxCnt <= r_rxCnt + 1'b1;
      end
    end
  end

  // Transmitter can reload on the last stop-bit cycle, so bytes go out back to back.
  logic             r_txBusy;
  logic             r_txd;
  logic [CNT_W-1:0] r_txCnt;
  logic [3:0]       r_txBit;
  logic [8:0]       r_txShift;
  logic             w_txReq;
  logic [7:0]       w_txByte;
  logic             w_txFree;
  logic             w_txLoad;

  assign w_txFree = !r_txBusy || (r_txCnt == BIT_LAST && r_txBit == 4'd9);
  assign w_txLoad = w_txReq && w_txFree && !uart.uart_cts;

  always_ff @(posedge clk_board_p) begin
    if (reset) begin
      r_txBusy  <= 1'b0;
      r_txd     <= 1'b1;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
    end else if (w_txLoad) begin
      r_txBusy  <= 1'b1;
      r_txd     <= 1'b0;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= {1'b1, w_txByte};
    end else if (r_txBusy) begin
      if (r_txCnt == BIT_LAST) begin
        r_txCnt <= '0;
        if (r_txBit == 4'd9) begin
          r_txBusy <= 1'b0;
          r_txd    <= 1'b1;
        end else begin
          r_txd     <= r_txShift[0];
          r_txShift <= {1'b1, r_txShift[8:1]};
          r_txBit   <= r_txBit + 4'd1;
        end
      end else begin
        r_txCnt <= r_txCnt + 1'b1;
      end
    end
  end

  logic [2:0]  r_state;
  logic        r_wr;
  logic [5:0]  r_len;
  logic [31:0] r_addr;
  logic [1:0]  r_byteCnt;
  logic [5:0]  r_wordCnt;
  logic [23:0] r_shift;
  logic        r_err;
  logic        r_ledRed;
  logic        r_cmtValid;
  logic [31:0] r_cmtAddr;
  logic [31:0] r_cmtData;
  logic        r_softRst;
  logic [8:0]  r_respIdx;
  logic [8:0]  w_respLast;
  logic [1:0]  w_dec;
  logic [1:0]  w_cmtDec;
  logic [31:0] w_rdData;
  logic        w_timeout;
  logic [31:0] r_regs [NUM_REGS];
  logic [31:0] r_rdBuf [64];

  assign w_dec      = decode(r_addr);
  assign w_cmtDec   = decode(r_cmtAddr);
  assign w_respLast = r_wr ? 9'd0 : {({1'b0, r_len} + 7'd1), 2'b00};

  always_comb begin
    w_rdData = 32'hDEAD_BEEF;
    case (w_dec)
      DEC_REG:  w_rdData = r_regs[regIdx(r_addr)];
      DEC_SOFT: w_rdData = 32'h0000_0000;
      DEC_ID:   w_rdData = 32'h0E6A_0001;
      default:  w_rdData = 32'hDEAD_BEEF;
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT + 2);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(RX_TIMEOUT);
  logic [TO_W-1:0] r_toCnt;
  always_ff @(posedge clk_board_p) begin
    if (reset || r_rxValid || !(r_state == ST_ADDR || r_state == ST_WDATA)) r_toCnt <= '0;
    else if (!w_timeout) r_toCnt <= r_toCnt + 1'b1;
  end
  assign w_timeout = (r_toCnt > TO_LIMIT);
`else
  logic [31:0] w_unusedTimeout;
  assign w_unusedTimeout = RX_TIMEOUT;
  assign w_timeout       = 1'b0;
`endif

  // Packet FSM; RX bytes seen in EXEC/RESP fall through unhandled and are lost.
  always_ff @(posedge clk_board_p) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr       <= 1'b0;
      r_len      <= '0;
      r_addr     <= '0;
      r_byteCnt  <= '0;
      r_wordCnt  <= '0;
      r_shift    <= '0;
      r_err      <= 1'b0;
      r_ledRed   <= 1'b0;
      r_cmtValid <= 1'b0;
      r_cmtAddr  <= '0;
      r_cmtData  <= '0;
      r_respIdx  <= '0;
    end else begin
      r_cmtValid <= 1'b0;
      if (r_softRst) r_ledRed <= 1'b0;
      if (w_timeout) begin
        r_state  <= ST_IDLE;
        r_ledRed <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_rxValid && r_rxData[7]) begin
              r_wr      <= r_rxData[6];
              r_len     <= r_rxData[5:0];
              r_byteCnt <= '0;
              r_wordCnt <= '0;
              r_err     <= 1'b0;
              r_state   <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (r_rxValid) begin
              r_addr    <= {r_addr[23:0], r_rxData};
              r_byteCnt <= r_byteCnt + 2'd1;
              if (r_byteCnt == 2'd3) r_state <= r_wr ? ST_WDATA : ST_EXEC;
            end
          end
          ST_WDATA: begin
            if (r_rxValid) begin
              r_shift   <= {r_shift[15:0], r_rxData};
              r_byteCnt <= r_byteCnt + 2'd1;
              if (r_byteCnt == 2'd3) begin
                r_cmtValid <= 1'b1;
                r_cmtAddr  <= r_addr;
                r_cmtData  <= {r_shift, r_rxData};
                r_addr     <= r_addr + 32'd4;
                r_wordCnt  <= r_wordCnt + 6'd1;
                if (w_dec == DEC_BAD) begin
                  r_err    <= 1'b1;
                  r_ledRed <= 1'b1;
                end
                if (r_wordCnt == r_len) begin
                  r_state   <= ST_RESP;
                  r_respIdx <= '0;
                end
              end
            end
          end
          ST_EXEC: begin
            r_addr    <= r_addr + 32'd4;
            r_wordCnt <= r_wordCnt + 6'd1;
            if (w_dec == DEC_BAD) begin
              r_err    <= 1'b1;
              r_ledRed <= 1'b1;
            end
            if (r_wordCnt == r_len) begin
              r_state   <= ST_RESP;
              r_respIdx <= '0;
            end
          end
          ST_RESP: begin
            if (w_txLoad) begin
              r_respIdx <= r_respIdx + 9'd1;
              if (r_respIdx == w_respLast) r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_board_p) begin
    if (!reset && r_state == ST_EXEC) r_rdBuf[r_wordCnt] <= w_rdData;
  end

  always_ff @(posedge clk_board_p) begin
    if (reset) r_softRst <= 1'b0;
    else       r_softRst <= r_cmtValid && (w_cmtDec == DEC_SOFT) && r_cmtData[0];
  end

  always_ff @(posedge clk_board_p) begin
    if (reset || r_softRst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_cmtValid && w_cmtDec == DEC_REG) begin
      r_regs[regIdx(r_cmtAddr)] <= r_cmtData;
    end
  end

  // Response stream: index 0 is the status byte, then read words MSB first.
  logic [7:0]  w_respOff;
  logic [31:0] w_respWord;
  always_comb begin
    w_respOff  = 8'(r_respIdx - 9'd1);
    w_respWord = r_rdBuf[w_respOff[7:2]];
    w_txByte   = {7'd0, r_err};
    if (r_respIdx != 9'd0) begin
      case (w_respOff[1:0])
        2'd0:    w_txByte = w_respWord[31:24];
        2'd1:    w_txByte = w_respWord[23:16];
        2'd2:    w_txByte = w_respWord[15:8];
        default: w_txByte = w_respWord[7:0];
      endcase
    end
  end

  assign w_txReq       = (r_state == ST_RESP);
  assign uart.uart_txd = r_txd;
  assign uart.uart_rts = (r_state == ST_EXEC) || (r_state == ST_RESP);
  assign LED_RED       = r_ledRed;
  assign LED_GREEN     = r_hb[HB_W-1];
  assign LED_BLUE      = r_rxBusy;
  assign LED_YELLOW    = r_txBusy;

endmodule

// File: tb/tb_uart_dbg_soc_top.sv
// Directed bench for uart_dbg_soc_top: host-side UART packets in, response bytes collected and compared.
`timescale 1ns/1ps
module tb_uart_dbg_soc_top;
  localparam int CPB = 16;

  logic clk;
  logic clkN;
  logic reset;
  logic sync0P;
  logic sync0N;
  logic ledRed, ledGreen, ledBlue, ledYellow;
  int checks = 0;
  int errors = 0;
  int stopErrors = 0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  logic [7:0] pktQ[$];

  uart_dbg_soc_top_if uartIf();

  uart_dbg_soc_top #(
    .SIMULATION(1), .CLKS_PER_BIT(CPB), .BASE_ADDR(32'h6000_0000),
    .NUM_REGS(256), .RX_TIMEOUT(4096)
  ) dut (
    .clk_board_p(clk), .clk_board_n(clkN), .reset(reset),
    .profpga_sync0_p(sync0P), .profpga_sync0_n(sync0N), .uart(uartIf),
    .LED_RED(ledRed), .LED_GREEN(ledGreen), .LED_BLUE(ledBlue), .LED_YELLOW(ledYellow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign clkN = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Host receiver: samples each DUT byte at bit centres and queues it.
  initial begin : txMonitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uartIf.uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uartIf.uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uartIf.uart_txd !== 1'b1) stopErrors++;
        rxQ.push_back(b);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uartIf.uart_rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic applyStimulus();
    while (pktQ.size() > 0) sendByte(pktQ.pop_front());
  endtask

  function automatic void pushPkt32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) pktQ.push_back(w[i*8 +: 8]);
  endfunction

  function automatic void pushExp32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) expQ.push_back(w[i*8 +: 8]);
  endfunction

  function automatic void packet(input logic [7:0] cmd, input logic [31:0] addr);
    pktQ.push_back(cmd);
    pushPkt32(addr);
  endfunction

  task automatic checkResponse(input string tag);
    int budget;
    budget = 200 * expQ.size() + 600;
    while (rxQ.size() < expQ.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({tag, "_count"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rxQ.size()) checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
    end
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic prevG;
    int n0, n1;
    reset = 1'b1;
    uartIf.uart_rxd = 1'b1;
    uartIf.uart_cts = 1'b0;
    sync0P = 1'b0;
    sync0N = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("rst_txd", {31'd0, uartIf.uart_txd}, 32'd1);
    checkOutput("rst_rts", {31'd0, uartIf.uart_rts}, 32'd0);
    checkOutput("rst_leds", {28'd0, ledRed, ledGreen, ledBlue, ledYellow}, 32'd0);
    reset = 1'b0;

    n0 = -1;
    n1 = -1;
    prevG = ledGreen;
    for (int cyc = 0; cyc < 300 && n1 < 0; cyc++) begin
      @(negedge clk);
      if (ledGreen !== prevG) begin
        if (n0 < 0) n0 = cyc;
        else        n1 = cyc;
        prevG = ledGreen;
      end
    end
    checkOutput("hb_first", 32'(n0), 32'd63);
    checkOutput("hb_period", 32'(n1 - n0), 32'd64);

    fork
      sendByte(8'h05);
      begin
        repeat (CPB * 3) @(negedge clk);
        checkOutput("rx_busy_blue", {31'd0, ledBlue}, 32'd1);
      end
    join

    pktQ.push_back(8'h12);
    packet(8'hC0, 32'h6000_0010); pushPkt32(32'hCAFE_BABE);
    applyStimulus();
    expQ.push_back(8'h00);
    checkResponse("wr_cafebabe");

    packet(8'h80, 32'h6000_0010);
    applyStimulus();
    checkOutput("rd_rts_busy", {31'd0, uartIf.uart_rts}, 32'd1);
    expQ.push_back(8'h00); pushExp32(32'hCAFE_BABE);
    checkResponse("rd_cafebabe");

    packet(8'hC1, 32'h6000_03F8); pushPkt32(32'h1111_1111); pushPkt32(32'h2222_2222);
    applyStimulus();
    expQ.push_back(8'h00);
    checkResponse("wr_burst_top");

    packet(8'h81, 32'h6000_03F8);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h1111_1111); pushExp32(32'h2222_2222);
    checkResponse("rd_burst_top");

    packet(8'hC0, 32'h6000_0400); pushPkt32(32'h0000_0001);
    applyStimulus();
    expQ.push_back(8'h00);
    checkResponse("wr_softrst");

    packet(8'h80, 32'h6000_03FC);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h0000_0000);
    checkResponse("rd_cleared_top");

    packet(8'h80, 32'h6000_0010);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h0000_0000);
    checkResponse("rd_cleared_low");

    checkOutput("red_before_bad", {31'd0, ledRed}, 32'd0);
    packet(8'h80, 32'h6000_0800);
    applyStimulus();
    expQ.push_back(8'h01); pushExp32(32'hDEAD_BEEF);
    checkResponse("rd_bad");
    checkOutput("red_after_bad", {31'd0, ledRed}, 32'd1);

    packet(8'h80, 32'h6000_0404);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h0E6A_0001);
    checkResponse("rd_id");

    packet(8'hC0, 32'h6000_0404); pushPkt32(32'h1234_5678);
    applyStimulus();
    expQ.push_back(8'h00);
    checkResponse("wr_id_ignored");

    packet(8'hC0, 32'h6000_0012); pushPkt32(32'h5555_5555);
    applyStimulus();
    expQ.push_back(8'h01);
    checkResponse("wr_misaligned");

    packet(8'hC0, 32'h6000_0400); pushPkt32(32'h0000_0001);
    applyStimulus();
    expQ.push_back(8'h00);
    checkResponse("wr_softrst2");
    repeat (4) @(negedge clk);
    checkOutput("red_soft_cleared", {31'd0, ledRed}, 32'd0);

    uartIf.uart_cts = 1'b1;
    packet(8'h80, 32'h6000_0404);
    applyStimulus();
    repeat (400) @(negedge clk);
    checkOutput("cts_hold_bytes", rxQ.size(), 32'd0);
    checkOutput("cts_hold_txd", {31'd0, uartIf.uart_txd}, 32'd1);
    checkOutput("cts_hold_rts", {31'd0, uartIf.uart_rts}, 32'd1);
    uartIf.uart_cts = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("tx_busy_yellow", {31'd0, ledYellow}, 32'd1);
    expQ.push_back(8'h00); pushExp32(32'h0E6A_0001);
    checkResponse("cts_release");

    pktQ.push_back(8'h80); pktQ.push_back(8'h60); pktQ.push_back(8'h00);
    applyStimulus();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst_rts", {31'd0, uartIf.uart_rts}, 32'd0);
    checkOutput("midrst_txd", {31'd0, uartIf.uart_txd}, 32'd1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    packet(8'h80, 32'h6000_0404);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h0E6A_0001);
    checkResponse("after_midrst");

`ifdef UART_RX_TIMEOUT_EN
    pktQ.push_back(8'h80); pktQ.push_back(8'h60); pktQ.push_back(8'h00);
    applyStimulus();
    repeat (4600) @(negedge clk);
    checkOutput("timeout_no_resp", rxQ.size(), 32'd0);
    checkOutput("timeout_red", {31'd0, ledRed}, 32'd1);
    packet(8'h80, 32'h6000_0404);
    applyStimulus();
    expQ.push_back(8'h00); pushExp32(32'h0E6A_0001);
    checkResponse("after_timeout");
`endif

    checkOutput("tx_stop_bits", 32'(stopErrors), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
